// File: rtl/sample_fifo_pkg.sv
// Shared defaults and width helpers for the sample_fifo EEG staging buffer.
package sample_fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the count can represent a completely full buffer.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_fifo_ram.sv
// Sample storage for sample_fifo: one synchronous write port, one asynchronous read port.
module sample_fifo_ram
  import sample_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately never reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sample_fifo.sv
// Handshaked circular sample FIFO feeding the first convolution layer.
// Define SAMPLE_FIFO_LEVEL_EN to expose the occupancy count on a level port.
module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
`ifdef SAMPLE_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wp, rp;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] ram_rdata;
  logic              wr, rd;

  // Status depends only on registered count and en, never on the partner handshake.
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = en & ~full;
  assign out_valid = en & ~empty;
  assign wr        = in_valid & in_ready;
  assign rd        = out_valid & out_ready;
  assign out_data  = out_valid ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && full) overflow <= 1'b1;
    end
  end

  sample_fifo_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr & ~flush & ~rst),
    .waddr(wp),
    .wdata(in_data),
    .raddr(rp),
    .rdata(ram_rdata)
  );

`ifdef SAMPLE_FIFO_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_sample_fifo.sv
// Scoreboard bench for sample_fifo: driver pushes expected samples, monitor checks every pop.
module tb_sample_fifo;
  import sample_fifo_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst, en, flush, in_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic              in_ready, out_valid, full, empty, overflow;
`ifdef SAMPLE_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  always #5 clk = ~clk;

  sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
`ifdef SAMPLE_FIFO_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  logic [DATA_W-1:0] sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int model_count = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, advances the bench's own occupancy model at the edge,
  // and returns 1 time unit after the edge so outputs can be sampled.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic r,
                               input logic e = 1'b1, input logic f = 1'b0);
    bit acc, rdf;
    in_valid = v; in_data = d; out_ready = r; en = e; flush = f;
    @(posedge clk);
    acc = e && !f && v && (model_count < DEPTH);
    rdf = e && !f && r && (model_count > 0);
    if (f) begin
      sb.delete();
      model_count = 0;
    end else begin
      if (acc) sb.push_back(d);
      model_count = model_count + int'(acc) - int'(rdf);
    end
    #1;
  endtask

  task automatic checkLevel(input string name, input int exp);
`ifdef SAMPLE_FIFO_LEVEL_EN
    checkOutput(name, 32'(level), 32'(exp));
`else
    checkOutput({name, "_empty"}, 32'(empty), 32'(exp == 0));
`endif
  endtask

  // Monitor: every presented-and-taken sample must match the head of the scoreboard;
  // an idle output must read as zero.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL pop_unexpected: got 0x%0h, expected no sample at %0t", out_data, $time);
        end else begin
          checkOutput("pop_data", 32'(out_data), 32'(sb.pop_front()));
        end
      end else if (out_valid === 1'b0) begin
        checkOutput("idle_out_data", 32'(out_data), 32'h0);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    applyStimulus(0, 8'h00, 0);
    applyStimulus(0, 8'h00, 0);
    rst = 1'b0;
    sb.delete();
    model_count = 0;
    #1;
    checkOutput("rst_empty",     32'(empty),     32'h1);
    checkOutput("rst_full",      32'(full),      32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data",  32'(out_data),  32'h0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'h1);
    checkOutput("rst_overflow",  32'(overflow),  32'h0);

    // Single sample latency and pop
    applyStimulus(1, 8'h11, 0);
    checkOutput("one_out_valid", 32'(out_valid), 32'h1);
    checkOutput("one_out_data",  32'(out_data),  32'h11);
    checkOutput("one_empty",     32'(empty),     32'h0);
    applyStimulus(0, 8'h00, 1);
    checkOutput("pop_empty",     32'(empty),     32'h1);
    checkOutput("pop_out_data",  32'(out_data),  32'h0);

    // Fill to DEPTH, then overflow attempt
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'(i), 0);
    checkOutput("fill_full",     32'(full),      32'h1);
    checkOutput("fill_in_ready", 32'(in_ready),  32'h0);
    checkOutput("fill_overflow", 32'(overflow),  32'h0);
    checkLevel("fill_level", 16);
    applyStimulus(1, 8'hAA, 0);
    checkOutput("ovf_overflow",  32'(overflow),  32'h1);
    checkOutput("ovf_full",      32'(full),      32'h1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 8'h00, 1);
    checkOutput("drain_empty",   32'(empty),     32'h1);
    checkOutput("drain_ovf",     32'(overflow),  32'h1);

    // Full with simultaneous write and read: read wins, write refused
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'h20 + 8'(i), 0);
    applyStimulus(1, 8'hBB, 1);
    checkOutput("fullrw_full",     32'(full),     32'h0);
    checkOutput("fullrw_in_ready", 32'(in_ready), 32'h1);
    checkOutput("fullrw_overflow", 32'(overflow), 32'h1);
    checkOutput("fullrw_head",     32'(out_data), 32'h21);
    checkLevel("fullrw_level", 15);

    // Drain to half full, then flush with a concurrent push
    for (int i = 0; i < 7; i++) applyStimulus(0, 8'h00, 1);
    checkLevel("half_level", 8);
    checkOutput("half_head", 32'(out_data), 32'h28);
    applyStimulus(1, 8'hCC, 0, 1'b1, 1'b1);
    checkOutput("flush_empty",    32'(empty),     32'h1);
    checkOutput("flush_overflow", 32'(overflow),  32'h0);
    applyStimulus(0, 8'h00, 0);
    checkOutput("flush_absent",   32'(out_valid), 32'h0);

    // Freeze with en=0 at count 4
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'h40 + 8'(i), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'hEE, 1, 1'b0);
      checkOutput("frz_in_ready",  32'(in_ready),  32'h0);
      checkOutput("frz_out_valid", 32'(out_valid), 32'h0);
      checkOutput("frz_out_data",  32'(out_data),  32'h0);
    end
    applyStimulus(0, 8'h00, 0);
    checkOutput("resume_head",  32'(out_data), 32'h40);
    checkLevel("resume_level", 4);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1);
    checkOutput("resume_not_empty", 32'(empty), 32'h0);
    applyStimulus(0, 8'h00, 1);
    checkOutput("resume_empty", 32'(empty), 32'h1);

    // Sustained stream at count 3 across pointer wrap
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'h50 + 8'(i), 0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 8'h60 + 8'(i), 1);
      checkLevel("stream_level", 3);
    end
    checkOutput("stream_head", 32'(out_data), 32'h60 + 32'd37);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1);
    checkOutput("stream_empty", 32'(empty), 32'h1);
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_fifo.md
# sample_fifo

Parametrised, handshaked sample buffer that stages EEG samples between the acquisition front end and the CNN convolution input. Replaces the single-register enable/hold stage with a DEPTH-entry circular FIFO with valid/ready flow control on both sides, flush, full/empty status and sticky overflow detection. Sits directly upstream of the first convolution layer's input window logic.

## Interface
- DATA_W, 8: sample width in bits.
- DEPTH, 16: number of entries; power of two, ≥ 2.
- clk  in  1  rising-edge clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when 0 the block freezes (no accept, no present, no state change).
- flush  in  1  synchronous clear of contents and overflow flag; state is otherwise kept.
- in_data  in  DATA_W  write sample.
- in_valid  in  1  producer has a sample.
- in_ready  out  1  FIFO can accept: en & !full.
- out_data  out  DATA_W  head sample; 0 when out_valid=0.
- out_valid  out  1  head sample present: en & !empty.
- out_ready  in  1  consumer takes head this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: a write was attempted while full and en=1.

## Operation
- Storage: DEPTH×DATA_W array; write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrap naturally modulo DEPTH; count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Write fires when in_valid & in_ready: mem[wp] ← in_data, wp+1.
- Read fires when out_valid & out_ready: rp+1.
- count: +1 on write only, −1 on read only, unchanged when both or neither fire.
- out_data = mem[rp] combinationally from the registered array (show-ahead); forced to 0 when out_valid=0.
- Full: in_ready=0 even if a read fires the same cycle (no pass-through on full). in_valid=1 while full and en=1 sets overflow; the sample is dropped.
- Empty: out_valid=0; a same-cycle write is not visible until the next cycle (no bypass).
- Priority per cycle: rst > flush > en=0 freeze > normal write/read.
- flush: wp, rp, count ← 0, overflow ← 0; write and read in the same cycle are discarded. Memory contents are not cleared.
- en=0: in_ready=0, out_valid=0, out_data=0, no pointer/count/overflow update.

## Timing
- Reset values: wp=rp=count=0, overflow=0 → empty=1, full=0, out_valid=0, out_data=0, in_ready=en.
- Latency: write accepted at edge N → out_valid=1 with that sample on out_data after edge N (cycle N+1).
- Throughput: one write and one read per cycle sustained when 0 < count < DEPTH.
- Status outputs (full, empty, in_ready, out_valid) are combinational from registered count and en; no combinational path from in_valid to in_ready or from out_ready to out_valid.
- Reset or flush asserted mid-stream: effective at that edge; a write/read presented in the same cycle is discarded.

## Configuration
- SAMPLE_FIFO_LEVEL_EN defined: adds output level [$clog2(DEPTH):0] = count, reset 0, same-cycle as full/empty.
- Not defined: level port absent; all other behaviour identical.

## Structure
- Package sample_fifo_pkg: default DATA_W/DEPTH localparams, ptr/count width function helpers (PTR_W = $clog2(DEPTH), CNT_W = PTR_W+1).
- One sub-module: sample_fifo_ram (DEPTH×DATA_W, one synchronous write port, one asynchronous read port); pointer/count/flag control stays in sample_fifo.

## Test plan
- Reset, en=1, push 0x11 at cycle 1 → cycle 2 out_valid=1, out_data=0x11, empty=0; pop → empty=1, out_data=0.
- Push 16 samples 0x00..0x0F with out_ready=0 → full=1, in_ready=0; 17th push 0xAA → overflow=1, drain yields 0x00..0x0F in order, 0xAA never appears.
- Steady stream with in_valid=out_ready=1, count held at 3 for 40 cycles across pointer wrap → count constant, output order equals input order.
- Full FIFO, in_valid=1 and out_ready=1 same cycle → read fires, write refused, count 16→15, overflow=1.
- Half-full with overflow=1, assert flush with in_valid=1 → next cycle empty=1, overflow=0, pushed sample absent.
- en=0 for 5 cycles with in_valid=out_ready=1 and count=4 → in_ready=out_valid=0, count stays 4; en=1 resumes from same head sample.
